// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports and the single data-memory port shared by
// data_memory_arbiter; slave = arbiter, master = requesters, memory = RAM side.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises req with we/addr/wdata stable and keeps them
    // until it sees its one-cycle ack; it drops req the cycle after ack, and a
    // req still high in that cycle is taken as a brand-new request.
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic              err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;

    logic              MemWrite;
    logic              MemRead;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, read_data,
        output ack0, ack1, err0, err1, rdata0, rdata1,
               MemWrite, MemRead, address, write_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1
    );

    modport memory (
        input  MemWrite, MemRead, address, write_data,
        output read_data
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two
// requesters; each grant is one memory cycle followed by a one-cycle ack.
module data_memory_arbiter #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    state_t            state, state_nxt;
    logic              rr;
    logic              owner;
    logic              lat_err;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              sel_port;
    logic              sel_we;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // rr only matters when both ports ask in the same IDLE cycle.
    always_comb begin
        sel_port  = (bus.req0 & bus.req1) ? rr : bus.req1;
        sel_we    = sel_port ? bus.we1    : bus.we0;
        sel_addr  = sel_port ? bus.addr1  : bus.addr0;
        sel_wdata = sel_port ? bus.wdata1 : bus.wdata0;
        sel_err   = (sel_addr >= LIMIT);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    if (sel_err)     state_nxt = RESP;
                    else if (sel_we) state_nxt = WRITE;
                    else             state_nxt = READ;
                end
            end
            WRITE:   state_nxt = RESP;
            READ:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= 1'b0;
            owner     <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        owner     <= sel_port;
                        lat_err   <= sel_err;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                    end
                end
                READ: begin
                    if (owner) rdata1_q <= bus.read_data;
                    else       rdata0_q <= bus.read_data;
                end
                RESP:    rr <= ~owner;
                default: ;
            endcase
        end
    end

    // Enables are gated by reset so an in-flight write is aborted, not committed.
    always_comb begin
        bus.ack0       = (state == RESP) & ~owner;
        bus.ack1       = (state == RESP) &  owner;
        bus.err0       = bus.ack0 & lat_err;
        bus.err1       = bus.ack1 & lat_err;
        bus.rdata0     = rdata0_q;
        bus.rdata1     = rdata1_q;
        bus.MemWrite   = (state == WRITE) & ~reset;
        bus.MemRead    = (state == READ)  & ~reset;
        bus.address    = ((state == WRITE) || (state == READ)) ? lat_addr : '0;
        bus.write_data = (state == WRITE) ? lat_wdata : '0;
        state_dbg      = state;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter that shares the single-ported data memory between two requesters, e.g. port 0 = MIPS datapath load/store stage, port 1 = debug/loader port. Each request is granted round-robin, sequenced as a one-cycle memory write or read, and closed with a one-cycle acknowledge. It is the only block allowed to drive the memory's MemWrite/MemRead/address/write_data pins.

## Interface
- DEPTH, 32: number of memory words; legal word addresses are 0..DEPTH-1
- ADDR_W, 32: address width of request ports and memory port
- DATA_W, 32: data width
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request; held high with fields stable until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack; 1 = address out of range, no access performed
- rdata0 / rdata1  out  DATA_W  last read result for that port; updated at ack of a successful read, otherwise held
- MemWrite  out  1  memory write enable
- MemRead  out  1  memory read enable
- address  out  ADDR_W  memory address
- write_data  out  DATA_W  memory write data
- read_data  in  DATA_W  memory read data

## Operation
- States: IDLE, WRITE, READ, RESP. Reset -> IDLE.
- IDLE: if no req, stay. Else select owner: if only one req, that port; if both, port rr (priority pointer). Latch owner, we, addr, wdata of selected port.
  - addr >= DEPTH -> RESP with err flag set (no memory access).
  - else we=1 -> WRITE, we=0 -> READ.
- WRITE (1 cycle): MemWrite=1, address/write_data = latched values; memory commits at the closing edge. -> RESP.
- READ (1 cycle): MemRead=1, address = latched addr; read_data captured into the owner's rdata register at the closing edge. -> RESP.
- RESP (1 cycle): ack of owner = 1, err of owner = latched err flag; other port's ack/err = 0. rr <= other port. -> IDLE.
- MemWrite = (state==WRITE) & ~reset; MemRead = (state==READ) & ~reset. address and write_data = 0 when not in WRITE/READ.
- Non-owner requests wait; their fields are not sampled until the arbiter returns to IDLE.
- A failed (err) or write access leaves that port's rdata unchanged.

## Timing
- Reset values: state=IDLE, rr=0 (port 0 priority), ack0/1=0, err0/1=0, rdata0/1=0, MemWrite=MemRead=0, address=write_data=0.
- Latency: req sampled high in IDLE in cycle n -> WRITE/READ in n+1 -> ack high in n+2. Error path: ack in n+1.
- Throughput: one access per 3 cycles (IDLE, op, RESP); error accesses 2 cycles.
- Requester must deassert req in the cycle after ack; req still high in that IDLE cycle is a new request.
- Both ports requesting continuously: grants alternate 0,1,0,1, starting with port 0 after reset.
- Simultaneous new req on the non-owner during RESP: served in the next IDLE cycle (it holds priority).
- Reset mid-operation: asserted during WRITE -> MemWrite gated low, write aborted, no ack; during READ -> no capture, no ack; during RESP -> ack still visible that cycle, all state cleared at the edge.
- Address boundary: addr=DEPTH-1 legal; addr=DEPTH and any higher bit set -> err.

## Test plan
- Single write then read, port 0: write 0xDEADBEEF to addr 5 (ack0 at n+2, MemWrite high exactly 1 cycle), read addr 5 -> rdata0=0xDEADBEEF, err0=0.
- Contention: req0 and req1 high together from reset, port 0 writes 0x11 @3, port 1 writes 0x22 @3 -> port 0 acked first, then port 1; read @3 returns 0x22; sustained requests alternate grants.
- Out of range: port 1 read addr 32 (DEPTH=32) -> ack1 with err1=1 one cycle after sampling, MemRead never asserted, rdata1 unchanged; addr 31 succeeds.
- Priority rotation: after serving port 1, both request -> port 0 served first; after port 0, both request -> port 1 served first.
- Reset during WRITE: port 0 writes 0xCAFE @7 over old 0x1234, reset high in WRITE cycle -> MemWrite low, no ack0, later read @7 returns 0x1234.
- Hold-off: port 1 requests while port 0 in READ; port 1 fields changed before its grant -> values at its IDLE grant cycle used; rdata0 unaffected by port 1 read.
